// File: rtl/bin2bcd_seq.sv
// Iterative binary-to-BCD converter (shift-and-add-3), one bit per clock.
// Accepts unsigned or two's-complement words; returns packed BCD, sign and digit count.
module bin2bcd_seq #(
  parameter int BIN_W     = 8,
  parameter int DIGITS    = 3,
  parameter int SIGNED_IN = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [BIN_W-1:0]             bin_in,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [4*DIGITS-1:0]          bcd_out,
  output logic                         sign_out,
  output logic [$clog2(DIGITS+1)-1:0]  ndig_out
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int NDW   = $clog2(DIGITS + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t            state, state_nxt;
  logic [BIN_W-1:0]  bin_sr, bin_nxt, mag;
  logic [BCD_W-1:0]  bcd_sr, bcd_nxt;
  logic [CNT_W-1:0]  cnt;
  logic              neg, sign_r, accept, last;

  // Pre-shift correction: any digit >= 5 gets +3 so the doubling carries into the next digit.
  function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int k = 0; k < DIGITS; k++)
      if (b[4*k +: 4] > 4'd4) r[4*k +: 4] = b[4*k +: 4] + 4'd3;
    return r;
  endfunction

  function automatic logic [NDW-1:0] ndig_of(input logic [BCD_W-1:0] b);
    logic [NDW-1:0] n;
    n = NDW'(1);
    for (int k = 0; k < DIGITS; k++)
      if (b[4*k +: 4] != 4'd0) n = NDW'(k + 1);
    return n;
  endfunction

  assign in_ready = (state == IDLE);
  assign accept   = in_valid && in_ready;
  assign last     = (cnt == CNT_W'(BIN_W - 1));

  // The most negative operand negates to 2^(BIN_W-1), which still fits as unsigned.
  always_comb begin
    neg = (SIGNED_IN != 0) && bin_in[BIN_W-1];
    mag = neg ? (~bin_in + BIN_W'(1)) : bin_in;
    {bcd_nxt, bin_nxt} = {add3(bcd_sr), bin_sr} << 1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = SHIFT;
      SHIFT:   if (last)      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_sr    <= '0;
      bcd_sr    <= '0;
      cnt       <= '0;
      sign_r    <= 1'b0;
      out_valid <= 1'b0;
      bcd_out   <= '0;
      sign_out  <= 1'b0;
      ndig_out  <= NDW'(1);
    end else if (accept) begin
      bin_sr <= mag;
      bcd_sr <= '0;
      cnt    <= '0;
      sign_r <= neg;
    end else if (state == SHIFT) begin
      bin_sr <= bin_nxt;
      bcd_sr <= bcd_nxt;
      cnt    <= cnt + CNT_W'(1);
      // Outputs are captured once, on the final shift, and then held through DONE.
      if (last) begin
        out_valid <= 1'b1;
        bcd_out   <= bcd_nxt;
        sign_out  <= sign_r;
        ndig_out  <= ndig_of(bcd_nxt);
      end
    end else if (state == DONE && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench: 8-bit unsigned and signed converters share one input stream;
// a 16-bit/5-digit converter is exercised back-to-back against a decimal model.
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid8, out_ready8, in_valid16, out_ready16;
  logic [7:0]  bin8;
  logic [15:0] bin16;

  logic        a_rdy, a_ov, a_sign, b_rdy, b_ov, b_sign, c_rdy, c_ov, c_sign;
  logic [11:0] a_bcd, b_bcd;
  logic [19:0] c_bcd;
  logic [1:0]  a_nd, b_nd;
  logic [2:0]  c_nd;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bin2bcd_seq #(.BIN_W(8), .DIGITS(3), .SIGNED_IN(0)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(a_rdy), .bin_in(bin8),
    .out_valid(a_ov), .out_ready(out_ready8), .bcd_out(a_bcd), .sign_out(a_sign), .ndig_out(a_nd));

  bin2bcd_seq #(.BIN_W(8), .DIGITS(3), .SIGNED_IN(1)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(b_rdy), .bin_in(bin8),
    .out_valid(b_ov), .out_ready(out_ready8), .bcd_out(b_bcd), .sign_out(b_sign), .ndig_out(b_nd));

  bin2bcd_seq #(.BIN_W(16), .DIGITS(5), .SIGNED_IN(0)) u_c (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(c_rdy), .bin_in(bin16),
    .out_valid(c_ov), .out_ready(out_ready16), .bcd_out(c_bcd), .sign_out(c_sign), .ndig_out(c_nd));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [19:0] bcd_model(input int unsigned v);
    logic [19:0] r;
    int unsigned p;
    r = '0;
    p = 1;
    for (int k = 0; k < 5; k++) begin
      r[4*k +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  function automatic logic [2:0] ndig_model(input int unsigned v);
    logic [2:0] n;
    int unsigned p;
    n = 3'd1;
    p = 1;
    for (int k = 0; k < 5; k++) begin
      if ((v / p) % 10 != 0) n = 3'(k + 1);
      p = p * 10;
    end
    return n;
  endfunction

  // Called at a negedge with out_ready8 = 1; returns at a negedge after the output handshake.
  task automatic conv8(input string tag, input logic [7:0] v,
                       input logic [11:0] ea, input logic [1:0] na,
                       input logic [11:0] eb, input logic sb, input logic [1:0] nb);
    chk({tag, ".rdy"}, 32'(a_rdy), 32'd1);
    bin8 = v;
    in_valid8 = 1'b1;
    @(posedge clk);
    #1 in_valid8 = 1'b0;
    bin8 = ~v;
    repeat (7) @(posedge clk);
    @(negedge clk);
    chk({tag, ".early"}, 32'(a_ov), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk({tag, ".a_ov"}, 32'(a_ov), 32'd1);
    chk({tag, ".b_ov"}, 32'(b_ov), 32'd1);
    chk({tag, ".a_bcd"}, 32'(a_bcd), 32'(ea));
    chk({tag, ".a_sign"}, 32'(a_sign), 32'd0);
    chk({tag, ".a_nd"}, 32'(a_nd), 32'(na));
    chk({tag, ".b_bcd"}, 32'(b_bcd), 32'(eb));
    chk({tag, ".b_sign"}, 32'(b_sign), 32'(sb));
    chk({tag, ".b_nd"}, 32'(b_nd), 32'(nb));
    @(posedge clk);
    @(negedge clk);
    chk({tag, ".post_rdy"}, 32'(a_rdy), 32'd1);
    chk({tag, ".post_ov"}, 32'(a_ov), 32'd0);
  endtask

  logic [15:0] words [5];
  int t_acc, t_prev;

  initial begin
    rst_n = 1'b0;
    in_valid8 = 1'b0; out_ready8 = 1'b1; bin8 = '0;
    in_valid16 = 1'b0; out_ready16 = 1'b1; bin16 = '0;
    t_acc = 0; t_prev = 0;
    repeat (2) @(negedge clk);
    chk("rst.rdy", 32'(a_rdy), 32'd1);
    chk("rst.ov", 32'(a_ov), 32'd0);
    chk("rst.bcd", 32'(a_bcd), 32'd0);
    chk("rst.sign", 32'(b_sign), 32'd0);
    chk("rst.nd", 32'(a_nd), 32'd1);
    chk("rst.c_nd", 32'(c_nd), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    conv8("u255", 8'd255, 12'h255, 2'd3, 12'h001, 1'b1, 2'd1);
    conv8("z0",   8'd0,   12'h000, 2'd1, 12'h000, 1'b0, 2'd1);
    conv8("u7",   8'd7,   12'h007, 2'd1, 12'h007, 1'b0, 2'd1);
    conv8("u100", 8'd100, 12'h100, 2'd3, 12'h100, 1'b0, 2'd3);
    conv8("s80",  8'h80,  12'h128, 2'd3, 12'h128, 1'b1, 2'd3);
    conv8("s7f",  8'h7F,  12'h127, 2'd3, 12'h127, 1'b0, 2'd3);
    conv8("s9c",  8'h9C,  12'h156, 2'd3, 12'h100, 1'b1, 2'd3);

    // Backpressure: 200 (signed view -56) held for 20 cycles while inputs churn.
    out_ready8 = 1'b0;
    bin8 = 8'd200;
    in_valid8 = 1'b1;
    @(posedge clk);
    #1 in_valid8 = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("bp.ov", 32'(a_ov), 32'd1);
    for (int i = 0; i < 20; i++) begin
      in_valid8 = i[0];
      bin8 = 8'($urandom);
      @(posedge clk);
      @(negedge clk);
      chk("bp.hold_ov", 32'(a_ov), 32'd1);
      chk("bp.hold_abcd", 32'(a_bcd), 32'h200);
      chk("bp.hold_and", 32'(a_nd), 32'd3);
      chk("bp.hold_bbcd", 32'(b_bcd), 32'h056);
      chk("bp.hold_bsign", 32'(b_sign), 32'd1);
      chk("bp.hold_bnd", 32'(b_nd), 32'd2);
      chk("bp.hold_rdy", 32'(a_rdy), 32'd0);
    end
    in_valid8 = 1'b0;
    out_ready8 = 1'b1;
    @(posedge clk);
    #1 out_ready8 = 1'b0;
    @(negedge clk);
    chk("bp.rel_rdy", 32'(a_rdy), 32'd1);
    chk("bp.rel_ov", 32'(a_ov), 32'd0);
    out_ready8 = 1'b1;
    conv8("bp.next", 8'd42, 12'h042, 2'd2, 12'h042, 1'b0, 2'd2);

    // Reset during the shift phase of a conversion of 200.
    bin8 = 8'd200;
    in_valid8 = 1'b1;
    @(posedge clk);
    #1 in_valid8 = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mrst.ov", 32'(a_ov), 32'd0);
    chk("mrst.bcd", 32'(a_bcd), 32'd0);
    chk("mrst.rdy", 32'(a_rdy), 32'd1);
    chk("mrst.b_rdy", 32'(b_rdy), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    conv8("mrst.42", 8'd42, 12'h042, 2'd2, 12'h042, 1'b0, 2'd2);

    // Wide converter, back-to-back with in_valid held high.
    words[0] = 16'd65535;
    for (int i = 1; i < 5; i++) words[i] = 16'($urandom_range(0, 65535));
    bin16 = words[0];
    in_valid16 = 1'b1;
    for (int w = 0; w < 5; w++) begin
      chk("w.rdy", 32'(c_rdy), 32'd1);
      @(posedge clk);
      t_acc = cyc;
      #1 bin16 = 16'h0;
      if (w > 0) chk("w.period", 32'(t_acc - t_prev), 32'd18);
      t_prev = t_acc;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (c_ov) break;
      end
      chk("w.ov", 32'(c_ov), 32'd1);
      if (w == 0) begin
        chk("w.max_bcd", 32'(c_bcd), 32'h65535);
        chk("w.max_nd", 32'(c_nd), 32'd5);
      end
      chk("w.bcd", 32'(c_bcd), 32'(bcd_model(int'(words[w]))));
      chk("w.nd", 32'(c_nd), 32'(ndig_model(int'(words[w]))));
      chk("w.sign", 32'(c_sign), 32'd0);
      @(posedge clk);
      @(negedge clk);
      if (w < 4) bin16 = words[w + 1];
    end
    in_valid16 = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bin2bcd_seq.md
# bin2bcd_seq

Parametrised, iterative binary-to-BCD converter that uses the shift-and-add-3 (double-dabble) algorithm, one bit per clock. It accepts a BIN_W-bit unsigned or two's-complement word over a valid/ready handshake and returns DIGITS packed BCD digits, a sign flag and a significant-digit count. It is the sequential, width-generic successor to the team's fixed 8-bit combinational encoder and feeds the decimal display and debug readout path next to the AES core.

## Interface
- BIN_W, 8: input word width; legal range 2..32.
- DIGITS, 3: output BCD digits. Must satisfy 10^DIGITS > 2^BIN_W when unsigned and 10^DIGITS > 2^(BIN_W-1) when signed. Illegal values are a configuration error and are not checked in RTL.
- SIGNED_IN, 0: 1 means bin_in is two's complement and is converted as sign plus magnitude.
- clk, input, 1: sole clock, rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- in_valid, input, 1: bin_in is valid.
- in_ready, output, 1: converter can accept a word. Equals (state == IDLE).
- bin_in, input, BIN_W: binary operand.
- out_valid, output, 1: result is valid.
- out_ready, input, 1: downstream accepts the result.
- bcd_out, output, 4*DIGITS: packed BCD. Digit k, with k=0 as the units digit, is bcd_out[4k+3:4k].
- sign_out, output, 1: the operand was negative. Always 0 when SIGNED_IN=0.
- ndig_out, output, $clog2(DIGITS+1): index of the most significant non-zero digit plus 1. Minimum value is 1.

## Operation
- The FSM has three states: IDLE, SHIFT and DONE.
- IDLE: on in_valid && in_ready, load the magnitude into the shift register and clear the BCD register and the bit counter. Latch the sign, then go to SHIFT.
- Magnitude rule: if SIGNED_IN && bin_in[BIN_W-1], magnitude = (~bin_in + 1) taken as BIN_W-bit unsigned, so the most negative value maps to 2^(BIN_W-1) exactly. Otherwise magnitude = bin_in.
- SHIFT, once per cycle:
  - Add 3 to every BCD digit that is greater than 4.
  - Shift {bcd, bin} left by one.
  - Increment the counter.
  - After the BIN_W-th shift, go to DONE and assert out_valid.
- DONE:
  - Compute ndig_out from the final digits and register it on entry to DONE.
  - Hold bcd_out, sign_out and ndig_out stable while out_valid is high.
  - On out_valid && out_ready, go to IDLE.
- Results are presented in order. The input is sampled only at the acceptance edge, so changes to bin_in afterwards have no effect.
- in_valid asserted outside IDLE is ignored. Upstream must hold in_valid and bin_in until in_ready is high.
- Zero input gives all-zero digits, sign_out=0 and ndig_out=1. Signed zero never produces sign_out=1.

## Timing
- Reset values, applied asynchronously while rst_n=0:
  - state = IDLE, so in_ready reads 1.
  - out_valid=0, bcd_out=0, sign_out=0, ndig_out=1.
  - Counter and shift register = 0.
- Reset release is taken synchronously with clk.
- Latency:
  - Acceptance at edge E0.
  - Shifts occur at edges E1 through E_BIN_W.
  - out_valid is high from E_BIN_W onward, i.e. BIN_W cycles after acceptance.
- With out_ready held at 1: the output handshake occurs at E_BIN_W+1 and in_ready is high after it. The minimum input-to-input period is BIN_W+2 cycles.
- With out_ready=0, out_valid and all outputs hold indefinitely. in_ready stays 0.
- Reset mid-operation, in SHIFT or DONE: the conversion is abandoned with no output. After release, the first acceptance behaves exactly as after power-up.
- in_valid and out_ready asserted in the same cycle: only the rule for the current state applies. A new word is never accepted in DONE.
- All outputs are registered except in_ready, which is decoded from state.

## Test plan
- Unsigned max, BIN_W=8: bin_in=255 → after 8 cycles, bcd_out=12'h255, sign_out=0, ndig_out=3, out_valid high exactly 8 cycles after acceptance.
- Zero and single digit: 0 → 12'h000 with ndig_out=1. Then 7 → 12'h007 with ndig_out=1. Then 100 → 12'h100 with ndig_out=3.
- Signed, SIGNED_IN=1, BIN_W=8, DIGITS=3:
  - 8'h80 → sign_out=1, bcd_out=12'h128.
  - 8'hFF → sign_out=1, bcd_out=12'h001.
  - 8'h7F → sign_out=0, bcd_out=12'h127.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid while toggling in_valid and bin_in → outputs remain stable and in_ready=0. Then pulse out_ready → IDLE next cycle, and the next word's result is correct.
- Reset mid-SHIFT: drop rst_n at shift 4 of a conversion of 200 → out_valid=0, bcd_out=0 and in_ready=1 immediately. After release, converting 42 gives 12'h042.
- Wide configuration, BIN_W=16, DIGITS=5: 65535 → 20'h65535 with ndig_out=5. Back-to-back random words with out_ready=1 → period is 18 cycles and every result matches the reference model.
